// File: rtl/m_wb_uarttx_if.sv
// m_wb_uarttx_if: Wishbone classic bus signals between the CPU-side master and the UART slave.
interface m_wb_uarttx_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic        ADR_I;
    logic        SEL_I;
    logic [7:0]  DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;
    modport slave (input CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, output DAT_O, ACK_O);
    modport master (output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I, input DAT_O, ACK_O);
endinterface

// File: rtl/m_wb_uarttx.sv
// m_wb_uarttx: Wishbone classic UART transmitter (8N1, LSB first) fed by a small byte FIFO.
module m_wb_uarttx #(
    parameter int CLKDIV   = 104,
    parameter int FIFOLOG2 = 2
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    m_wb_uarttx_if.slave  wb,
    output logic          TXD,
    output logic          txempty
);
    localparam int DEPTH = 1 << FIFOLOG2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t              r_state, w_state_n;
    logic [FIFOLOG2:0]   r_count;
    logic [FIFOLOG2-1:0] r_rd, r_wr;
    logic [7:0]          r_mem [DEPTH];
    logic [7:0]          r_shreg;
    logic [15:0]         r_baud;
    logic [2:0]          r_bitcnt;
    logic                r_ovf, r_ack, r_txd;
    logic [31:0]         r_dat;
    logic                w_req, w_wr, w_full, w_nonempty, w_push, w_pop, w_tick, w_txd_n;
    logic                w_ovf_set, w_ovf_clr;
    assign wb.ACK_O   = r_ack;
    assign wb.DAT_O   = r_dat;
    assign TXD        = r_txd;
    assign w_req      = wb.CYC_I & wb.STB_I & ~r_ack;
    assign w_wr       = w_req & wb.WE_I & wb.SEL_I;
    assign w_full     = r_count == (FIFOLOG2+1)'(DEPTH);
    assign w_nonempty = r_count != '0;
    assign w_push     = w_wr & ~wb.ADR_I & ~w_full;
    assign w_ovf_set  = w_wr & ~wb.ADR_I & w_full;
    assign w_ovf_clr  = w_wr & wb.ADR_I & wb.DAT_I[2];
    assign w_tick     = r_baud == '0;
    assign txempty    = ~w_nonempty & (r_state == IDLE);
    always_ff @(posedge CLK_I)
        r_state <= RST_I ? IDLE : w_state_n;
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (w_nonempty) w_state_n = START;
            START:   if (w_tick) w_state_n = DATA;
            DATA:    if (w_tick && r_bitcnt == 3'd7) w_state_n = STOP;
            STOP:    if (w_tick) w_state_n = w_nonempty ? START : IDLE;
            default: w_state_n = IDLE;
        endcase
    end
    // TXD is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        w_pop   = w_nonempty & ((r_state == IDLE) | ((r_state == STOP) & w_tick));
        w_txd_n = (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shreg[0] : 1'b1;
    end
    always_ff @(posedge CLK_I)
        if (w_push) r_mem[r_wr] <= wb.DAT_I;
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_txd    <= 1'b1;
            r_count  <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_ovf    <= 1'b0;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
        end else begin
            r_ack   <= w_req;
            r_txd   <= w_txd_n;
            if (w_req & ~wb.WE_I) r_dat <= wb.ADR_I ? {29'b0, r_ovf, ~txempty, w_full} : 32'(r_count);
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (FIFOLOG2+1)'(w_push) - (FIFOLOG2+1)'(w_pop);
            r_ovf   <= (r_ovf | w_ovf_set) & ~w_ovf_clr;
            r_baud  <= (r_state == IDLE || w_tick) ? 16'(CLKDIV-1) : r_baud - 1'b1;
            if (r_state == START) r_bitcnt <= '0;
            else if (r_state == DATA && w_tick) r_bitcnt <= r_bitcnt + 1'b1;
            if (w_pop) r_shreg <= r_mem[r_rd];
            else if (r_state == DATA && w_tick) r_shreg <= r_shreg >> 1;
        end
    end
endmodule

// File: tb/tb_m_wb_uarttx.sv
// tb_m_wb_uarttx: randomized bus stimulus; expected TXD waveform built from 8N1 framing of the written bytes.
module tb_m_wb_uarttx;
    localparam int CLKDIV = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txd, txempty;
    logic [31:0] rd;
    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          failures = 0;
    m_wb_uarttx_if bus();
    m_wb_uarttx #(.CLKDIV(CLKDIV), .FIFOLOG2(2)) dut (
        .CLK_I(clk), .RST_I(rst), .wb(bus), .TXD(txd), .txempty(txempty));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
    task automatic wb_cycle(input logic we, input logic adr, input logic sel, input logic [7:0] d);
        logic got = 1'b0;
        @(negedge clk);
        bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = we; bus.ADR_I = adr; bus.SEL_I = sel; bus.DAT_I = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            got = bus.ACK_O;
        end
        checks++;
        if (!got) begin failures++; $display("FAIL ack_timeout got 0 exp 1"); end
        rd = bus.DAT_O;
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
    endtask
    // Called right after the ack of the write that starts transmission from idle.
    task automatic check_frames(input int n);
        logic [7:0] b;
        logic       e;
        int         k;
        @(posedge clk); #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL pre_start txd got %b exp 1", txd); end
        for (int f = 0; f < n; f++) begin
            b = exp_q[f];
            for (int j = 0; j < 10*CLKDIV; j++) begin
                @(posedge clk); #1;
                k = j / CLKDIV;
                e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                checks++;
                if (txd !== e) begin failures++; $display("FAIL frame %0d cyc %0d txd got %b exp %b", f, j, txd, e); end
            end
        end
        checks++;
        if (txempty !== 1'b1) begin failures++; $display("FAIL end_txempty got %b exp 1", txempty); end
    endtask
    task automatic test_reset;
        int lows = 0, acks = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL rst_txd got %b exp 1", txd); end
        checks++; if (txempty !== 1'b1) begin failures++; $display("FAIL rst_txempty got %b exp 1", txempty); end
        checks++; if (bus.ACK_O !== 1'b0) begin failures++; $display("FAIL rst_ack got %b exp 0", bus.ACK_O); end
        checks++; if (bus.DAT_O !== 32'd0) begin failures++; $display("FAIL rst_dat got %h exp 0", bus.DAT_O); end
        @(negedge clk); rst = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (txd !== 1'b1 || txempty !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL idle_line bad_cycles got %0d exp 0", lows); end
        wb_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL idle_status got %h exp 0", rd); end
        @(posedge clk); #1;
        checks++; if (bus.ACK_O !== 1'b0) begin failures++; $display("FAIL ack_single got %b exp 0", bus.ACK_O); end
        @(negedge clk);
        bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b0; bus.ADR_I = 1'b0; bus.SEL_I = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.ACK_O === 1'b1) acks++;
        end
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
        checks++; if (acks != 2) begin failures++; $display("FAIL stb_held acks got %0d exp 2", acks); end
    endtask
    task automatic test_single;
        exp_q = {8'hA5};
        wb_cycle(1'b1, 1'b0, 1'b1, 8'hA5);
        check_frames(1);
    endtask
    task automatic test_back_to_back;
        exp_q = {8'h55, 8'h0F};
        wb_cycle(1'b1, 1'b0, 1'b1, 8'h55);
        fork
            check_frames(2);
            wb_cycle(1'b1, 1'b0, 1'b1, 8'h0F);
        join
    endtask
    task automatic test_overflow;
        logic [7:0] b[6];
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        exp_q = {b[0], b[1], b[2], b[3], b[4]};
        wb_cycle(1'b1, 1'b0, 1'b1, b[0]);
        fork
            check_frames(5);
            begin
                for (int i = 1; i < 6; i++) wb_cycle(1'b1, 1'b0, 1'b1, b[i]);
                wb_cycle(1'b0, 1'b1, 1'b1, 8'h00);
                checks++; if (rd !== 32'd7) begin failures++; $display("FAIL ovf_status got %h exp 7", rd); end
                wb_cycle(1'b1, 1'b1, 1'b1, 8'h04);
                wb_cycle(1'b0, 1'b1, 1'b1, 8'h00);
                checks++; if (rd !== 32'd3) begin failures++; $display("FAIL ovf_clear got %h exp 3", rd); end
            end
        join
        wb_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL drained_status got %h exp 0", rd); end
    endtask
    task automatic test_count;
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
        wb_cycle(1'b1, 1'b0, 1'b1, exp_q[0]);
        fork
            check_frames(4);
            begin
                for (int i = 1; i < 4; i++) wb_cycle(1'b1, 1'b0, 1'b1, exp_q[i]);
                wb_cycle(1'b0, 1'b0, 1'b1, 8'h00);
                checks++; if (rd !== 32'd3) begin failures++; $display("FAIL count_read got %h exp 3", rd); end
                wb_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
                wb_cycle(1'b0, 1'b0, 1'b1, 8'h00);
                checks++; if (rd !== 32'd3) begin failures++; $display("FAIL sel0_count got %h exp 3", rd); end
            end
        join
    endtask
    task automatic test_random;
        int n = $urandom_range(1, 4);
        exp_q = {};
        for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
        wb_cycle(1'b1, 1'b0, 1'b1, exp_q[0]);
        fork
            check_frames(n);
            for (int i = 1; i < n; i++) wb_cycle(1'b1, 1'b0, 1'b1, exp_q[i]);
        join
    endtask
    task automatic test_reset_mid;
        int lows = 0;
        wb_cycle(1'b1, 1'b0, 1'b1, 8'($urandom) & 8'hF7);
        wb_cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
        wb_cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
        repeat (13) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_rst_txd got %b exp 1", txd); end
        @(negedge clk); rst = 1'b0;
        wb_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mid_rst_count got %h exp 0", rd); end
        repeat (60) begin
            @(posedge clk); #1;
            if (txd !== 1'b1 || txempty !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL mid_rst_quiet bad_cycles got %0d exp 0", lows); end
    endtask
    initial begin
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0; bus.ADR_I = 1'b0; bus.SEL_I = 1'b0; bus.DAT_I = 8'h00;
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_count;
        repeat (3) test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
